regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; next generation of the core's 2R/1W register file.
- Configurable data width, depth, and read/write port counts.
- Adds registered reads with write-first bypass, deterministic multi-write priority, optional hard-wired zero register, and a hardware clear engine that zeroes the array after reset or on request.
- Sits in the decode/writeback stage of the core; one instance serves all issue lanes.

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers; power of two, >= 2
- NUM_RD, 2, read ports, >= 1
- NUM_WR, 1, write ports, >= 1
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is ordinary
- ADDR_W, $clog2(DEPTH), derived; not to be overridden

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active low
- clear_req  in  1  pulse: start a full-array clear
- busy  out  1  clear engine active; writes ignored, reads return 0
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses, port k at [k*ADDR_W +: ADDR_W]
- wr_data  in  NUM_WR*DATA_W  packed write data
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses
- rd_data  out  NUM_RD*DATA_W  packed registered read data

Behaviour:
- Reset (rst_n low, async):
  - rd_data = 0; busy = 1; FSM = CLEAR; clear counter = 0.
  - The array itself is not reset asynchronously.
- FSM states: IDLE, CLEAR.
  - CLEAR: each cycle writes 0 to array[cnt], then cnt increments. When cnt == DEPTH-1 is written, the next state is IDLE and busy = 0 the following cycle.
  - Clear takes exactly DEPTH cycles after rst_n deasserts.
  - IDLE with clear_req = 1: next state CLEAR, cnt = 0, busy = 1 the next cycle.
  - clear_req during CLEAR: ignored; the sweep is not restarted.
  - rst_n asserted mid-clear: the sweep restarts from 0.
- Writes, IDLE only: on each clk edge, for every port k with wr_en[k] = 1, array[wr_addr[k]] <= wr_data[k].
  - Same-address multi-write: the highest-numbered port wins.
  - With ZERO_REG = 1, writes to address 0 are dropped.
  - While busy = 1, all wr_en are ignored.
- Reads: 1-cycle latency. rd_data[j] is registered from rd_addr[j] sampled on the same edge.
  - Write-first bypass: if any enabled write port in that cycle targets rd_addr[j], rd_data[j] next cycle = that write data, using the same highest-port priority. This applies only when the write is not dropped (addr 0 with ZERO_REG = 1, or busy).
  - ZERO_REG = 1 and rd_addr[j] == 0: rd_data[j] = 0.
  - busy = 1 in the sampling cycle: rd_data[j] = 0.
  - All read ports are independent; identical addresses on several ports are legal.
- rd_data holds its value only until the next edge; there is no read enable. A new sample is taken every cycle.
- Out-of-range addresses cannot occur because DEPTH is a power of two.
- No combinational path from any input to any output.

Test Plan:
- Reset, then clear: assert rst_n low, release; busy = 1 for exactly 32 cycles (DEPTH = 32), then 0. Read addr 5 -> rd_data = 0x00000000.
- Write then read: write 0xDEADBEEF to r7. Read r7 the next cycle -> rd_data = 0xDEADBEEF one cycle after the address is applied.
- Bypass: same cycle, write 0x12345678 to r3 and read r3 on both ports -> both rd_data = 0x12345678 next cycle, not the old value.
- Zero register (ZERO_REG = 1): write 0xFFFFFFFF to r0 while reading r0 -> rd_data = 0. A later read of r0 -> 0.
- Multi-write priority (NUM_WR = 2): both ports write r9, port0 = 0xAAAA0000, port1 = 0x0000BBBB -> r9 reads 0x0000BBBB. A bypass read in the same cycle also returns 0x0000BBBB.
- clear_req and mid-clear reset:
  - Fill r1..r4 with nonzero values, pulse clear_req -> busy high 32 cycles; writes during busy are dropped; afterwards all of r1..r4 read 0.
  - Assert rst_n at clear cycle 10 -> busy stays 1, and the full 32-cycle sweep restarts after release.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: registered reads with write-first bypass,
// highest-port-wins write priority, optional hard-wired zero register and
// a clear engine that sweeps the array to zero after reset or on request.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_req,
    output logic                       busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data
);

    typedef enum logic {S_IDLE, S_CLEAR} state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  cnt_q;
    logic               busy_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [NUM_WR-1:0]  wr_act;

    assign busy = busy_q;

    // Effective write enables: nothing lands while clearing, and r0 is
    // read-only when it is the hard-wired zero register.
    always_comb begin
        wr_act = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            wr_act[k] = wr_en[k] && !busy_q &&
                        !(ZERO_REG != 0 && wr_addr[k*ADDR_W +: ADDR_W] == '0);
        end
    end

    // Clear-engine FSM; busy is a registered copy of the CLEAR state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (clear_req) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    cnt_q <= cnt_q + ADDR_W'(1);
                    if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_CLEAR;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Array update: clear sweep, or port writes in ascending order so the
    // highest-numbered port wins on an address collision.
    always_ff @(posedge clk) begin
        if (busy_q) begin
            mem_q[cnt_q] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_act[k])
                    mem_q[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
            end
        end
    end

    for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_d;
        logic [DATA_W-1:0] rd_q;

        assign ra = rd_addr[j*ADDR_W +: ADDR_W];

        // Next read value: array, overridden by the winning same-cycle write,
        // forced to zero for r0 (when hard-wired) or while clearing.
        always_comb begin
            rd_d = mem_q[ra];
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_act[k] && wr_addr[k*ADDR_W +: ADDR_W] == ra)
                    rd_d = wr_data[k*DATA_W +: DATA_W];
            end
            if ((ZERO_REG != 0 && ra == '0) || busy_q)
                rd_d = '0;
        end

        // Read output register, sampled every cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rd_q <= '0;
            else        rd_q <= rd_d;
        end

        assign rd_data[j*DATA_W +: DATA_W] = rd_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp (DEPTH=32, 2 read ports, 2 write ports, zero reg on).
// Reference model is a plain array of register contents plus a "clear in
// progress" countdown; read expectations come from the architectural rules.
module tb_regfile_mp;
    localparam int DW = 32, DEPTH = 32, NRD = 2, NWR = 2, AW = 5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            clear_req = 1'b0;
    logic            busy;
    logic [NWR-1:0]  wr_en = '0;
    logic [NWR*AW-1:0] wr_addr = '0;
    logic [NWR*DW-1:0] wr_data = '0;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic [NRD*DW-1:0] rd_data;

    regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .NUM_WR(NWR), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .clear_req(clear_req), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [DW-1:0] mdl [DEPTH];
    bit   m_busy, in_rst;
    int   clr_left;
    logic [DW-1:0] exp0, exp1;
    logic exp_busy;

    function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] ra, input logic [1:0] we,
                                             input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                                             input logic [AW-1:0] wa1, input logic [DW-1:0] wd1);
        if (in_rst || m_busy || ra == 0) return '0;
        if (we[1] && wa1 == ra) return wd1;
        if (we[0] && wa0 == ra) return wd0;
        return mdl[ra];
    endfunction

    task automatic model_reset();
        in_rst = 1; m_busy = 1; clr_left = DEPTH;
        foreach (mdl[i]) mdl[i] = '0;
    endtask

    // Drive one cycle of stimulus, predict outputs, advance past the edge.
    task automatic step(input logic [1:0] we, input logic [AW-1:0] wa0, input logic [DW-1:0] wd0,
                        input logic [AW-1:0] wa1, input logic [DW-1:0] wd1,
                        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1, input logic clr);
        wr_en = we; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
        rd_addr = {ra1, ra0}; clear_req = clr;
        exp0 = rd_ref(ra0, we, wa0, wd0, wa1, wd1);
        exp1 = rd_ref(ra1, we, wa0, wd0, wa1, wd1);
        if (!in_rst) begin
            if (m_busy) begin
                clr_left--;
                if (clr_left == 0) m_busy = 0;
            end else begin
                if (we[0] && wa0 != 0) mdl[wa0] = wd0;
                if (we[1] && wa1 != 0) mdl[wa1] = wd1;
                if (clr) begin
                    m_busy = 1; clr_left = DEPTH;
                    foreach (mdl[i]) mdl[i] = '0;
                end
            end
        end
        exp_busy = in_rst | m_busy;
        @(posedge clk); #1;
        clear_req = 1'b0; wr_en = '0;
    endtask

    task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        step(2'b00, 0, 0, 0, 0, ra0, ra1, 1'b0);
    endtask

    task automatic test_reset();
        int n;
        #2 rst_n = 1'b0; model_reset(); #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
        total++; if (rd_data !== '0) begin bad++; $display("FAIL reset_rd: got %h want 0", rd_data); end
        idle(5, 6);
        total++; if (busy !== 1'b1 || rd_data !== '0) begin bad++; $display("FAIL reset_hold: got busy=%b rd=%h want 1/0", busy, rd_data); end
        rst_n = 1'b1; in_rst = 0;
        n = 0;
        do begin
            idle(5, 5); n++;
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL reset_sweep_busy: got %b want %b (cycle %0d)", busy, exp_busy, n); end
        end while (busy === 1'b1 && n < 100);
        total++; if (n != DEPTH) begin bad++; $display("FAIL reset_clear_len: got %0d want %0d", n, DEPTH); end
        idle(5, 5);
        total++; if (rd_data[DW-1:0] !== 32'h0) begin bad++; $display("FAIL reset_read5: got %h want 0", rd_data[DW-1:0]); end
    endtask

    task automatic test_write_read();
        step(2'b01, 7, 32'hDEADBEEF, 0, 0, 1, 2, 1'b0);
        idle(7, 1);
        total++; if (rd_data[DW-1:0] !== 32'hDEADBEEF || rd_data[DW-1:0] !== exp0) begin bad++; $display("FAIL write_read: got %h want %h", rd_data[DW-1:0], 32'hDEADBEEF); end
    endtask

    task automatic test_bypass();
        step(2'b01, 3, 32'h0BAD0BAD, 0, 0, 0, 0, 1'b0);
        step(2'b01, 3, 32'h12345678, 0, 0, 3, 3, 1'b0);
        total++; if (rd_data[DW-1:0] !== 32'h12345678) begin bad++; $display("FAIL bypass_p0: got %h want 12345678", rd_data[DW-1:0]); end
        total++; if (rd_data[2*DW-1:DW] !== 32'h12345678) begin bad++; $display("FAIL bypass_p1: got %h want 12345678", rd_data[2*DW-1:DW]); end
    endtask

    task automatic test_zero_reg();
        step(2'b01, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 1'b0);
        total++; if (rd_data !== '0) begin bad++; $display("FAIL zero_bypass: got %h want 0", rd_data); end
        step(2'b10, 0, 0, 0, 32'hFFFFFFFF, 0, 7, 1'b0);
        total++; if (rd_data[DW-1:0] !== 32'h0) begin bad++; $display("FAIL zero_bypass_p1: got %h want 0", rd_data[DW-1:0]); end
        idle(0, 0);
        total++; if (rd_data !== '0) begin bad++; $display("FAIL zero_later: got %h want 0", rd_data); end
    endtask

    task automatic test_priority();
        step(2'b11, 9, 32'hAAAA0000, 9, 32'h0000BBBB, 9, 7, 1'b0);
        total++; if (rd_data[DW-1:0] !== 32'h0000BBBB) begin bad++; $display("FAIL prio_bypass: got %h want 0000bbbb", rd_data[DW-1:0]); end
        idle(7, 9);
        total++; if (rd_data[2*DW-1:DW] !== 32'h0000BBBB) begin bad++; $display("FAIL prio_stored: got %h want 0000bbbb", rd_data[2*DW-1:DW]); end
        total++; if (rd_data[DW-1:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL prio_other: got %h want deadbeef", rd_data[DW-1:0]); end
    endtask

    task automatic test_clear();
        int n;
        step(2'b11, 1, 32'h11111111, 2, 32'h22222222, 0, 0, 1'b0);
        step(2'b11, 3, 32'h33333333, 4, 32'h44444444, 1, 2, 1'b0);
        total++; if (rd_data !== {32'h22222222, 32'h11111111}) begin bad++; $display("FAIL clear_fill: got %h want 2222222211111111", rd_data); end
        idle(3, 4);
        step(2'b00, 0, 0, 0, 0, 3, 4, 1'b1);
        total++; if (rd_data !== {32'h44444444, 32'h33333333}) begin bad++; $display("FAIL clear_fill2: got %h want 4444444433333333", rd_data); end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step(2'b11, AW'($urandom_range(1, 4)), $urandom, AW'($urandom_range(1, 4)), $urandom, 1, 2, n == 5);
            n++;
            total++; if (rd_data !== '0 || busy !== exp_busy) begin bad++; $display("FAIL clear_busy: got rd=%h busy=%b want 0/%b", rd_data, busy, exp_busy); end
        end
        total++; if (n != DEPTH) begin bad++; $display("FAIL clear_len: got %0d want %0d", n, DEPTH); end
        idle(1, 2);
        total++; if (rd_data !== '0) begin bad++; $display("FAIL clear_r12: got %h want 0", rd_data); end
        idle(3, 4);
        total++; if (rd_data !== '0) begin bad++; $display("FAIL clear_r34: got %h want 0", rd_data); end
    endtask

    task automatic test_mid_clear_reset();
        int n;
        step(2'b01, 6, 32'h66666666, 0, 0, 0, 0, 1'b1);
        for (int i = 0; i < 10; i++) idle(6, 6);
        rst_n = 1'b0; model_reset(); #1;
        total++; if (busy !== 1'b1 || rd_data !== '0) begin bad++; $display("FAIL midrst_assert: got busy=%b rd=%h want 1/0", busy, rd_data); end
        idle(6, 6); idle(6, 6);
        rst_n = 1'b1; in_rst = 0;
        n = 0;
        do begin idle(6, 6); n++; end while (busy === 1'b1 && n < 100);
        total++; if (n != DEPTH) begin bad++; $display("FAIL midrst_len: got %0d want %0d", n, DEPTH); end
        idle(6, 6);
        total++; if (rd_data !== '0) begin bad++; $display("FAIL midrst_r6: got %h want 0", rd_data); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(2'($urandom), AW'($urandom_range(0, 7)), $urandom, AW'($urandom_range(0, 7)), $urandom,
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), $urandom_range(0, 63) == 0);
            total++; if (rd_data[DW-1:0] !== exp0) begin bad++; $display("FAIL rand_rd0 @%0d: got %h want %h", i, rd_data[DW-1:0], exp0); end
            total++; if (rd_data[2*DW-1:DW] !== exp1) begin bad++; $display("FAIL rand_rd1 @%0d: got %h want %h", i, rd_data[2*DW-1:DW], exp1); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL rand_busy @%0d: got %b want %b", i, busy, exp_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_priority();
        test_clear();
        test_mid_clear_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
